// File: rtl/jtoutrun_subbus.sv
// Main-CPU initiator for the sub CPU bus-request port: request, settle, transfer, DTACK handshake.
// Optional JTOUTRUN_SUBHOLD_EN keeps the sub bus granted for HOLD cycles between back-to-back accesses.
module jtoutrun_subbus #(
  parameter int SETTLE  = 2,
  parameter int TOW     = 10,
  parameter int TIMEOUT = 1000,
  parameter int HOLD    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        main_cs,
  input  logic [18:0] main_A,
  input  logic [1:0]  main_dsn,
  input  logic        main_rnw,
  input  logic [15:0] main_dout,
  output logic [15:0] main_din,
  output logic        main_ok,
  output logic        sub_br,
  output logic [18:0] sub_A,
  output logic [1:0]  sub_dsn,
  output logic        sub_rnw,
  output logic [15:0] sub_dout,
  input  logic [15:0] sub_din,
  input  logic        sub_ok,
  output logic        tout
);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {IDLE, REQ, ACCESS, DONE, KEEP} state_t;

  state_t      state_q, state_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic [TOW-1:0] to_q, to_d;
  logic        sub_br_q, sub_br_d;
  logic        main_ok_q, main_ok_d;
  logic [15:0] main_din_q, main_din_d;
  logic        tout_q, tout_d;
  logic [18:0] sub_a_q, sub_a_d;
  logic [1:0]  sub_dsn_q, sub_dsn_d;
  logic        sub_rnw_q, sub_rnw_d;
  logic [15:0] sub_dout_q, sub_dout_d;
  logic        latch;
`ifdef JTOUTRUN_SUBHOLD_EN
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  logic [HW-1:0] hold_q, hold_d;
`endif

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    to_d       = to_q;
    sub_br_d   = sub_br_q;
    main_ok_d  = main_ok_q;
    main_din_d = main_din_q;
    tout_d     = tout_q;
    sub_a_d    = sub_a_q;
    sub_dsn_d  = sub_dsn_q;
    sub_rnw_d  = sub_rnw_q;
    sub_dout_d = sub_dout_q;
    latch      = 1'b0;
`ifdef JTOUTRUN_SUBHOLD_EN
    hold_d     = hold_q;
`endif
    case (state_q)
      IDLE: if (main_cs && !main_ok_q) begin
        latch    = 1'b1;
        sub_br_d = 1'b1;
        to_d     = '0;
        state_d  = REQ;
      end
      REQ, ACCESS: begin
        // abort beats timeout, timeout beats a same-cycle grant
        if (!main_cs) begin
          sub_br_d = 1'b0;
          state_d  = IDLE;
        end else if (to_q == TOW'(TIMEOUT - 1)) begin
          main_din_d = 16'hFFFF;
          main_ok_d  = 1'b1;
          tout_d     = 1'b1;
          state_d    = DONE;
        end else begin
          to_d = to_q + 1'b1;
          if (state_q == REQ) begin
            if (sub_ok) begin
              settle_d = SW'(SETTLE);
              state_d  = ACCESS;
            end
          end else if (settle_q != '0) begin
            settle_d = settle_q - 1'b1;
          end else if (sub_ok) begin
            if (sub_rnw_q) main_din_d = sub_din;
            main_ok_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: if (!main_cs) begin
        main_ok_d = 1'b0;
`ifdef JTOUTRUN_SUBHOLD_EN
        hold_d    = '0;
        state_d   = KEEP;
`else
        sub_br_d  = 1'b0;
        state_d   = IDLE;
`endif
      end
`ifdef JTOUTRUN_SUBHOLD_EN
      // bus still granted: a new access skips the request phase
      KEEP: if (main_cs) begin
        latch    = 1'b1;
        to_d     = '0;
        settle_d = SW'(SETTLE);
        state_d  = ACCESS;
      end else if (hold_q == HW'(HOLD - 1)) begin
        sub_br_d = 1'b0;
        state_d  = IDLE;
      end else begin
        hold_d = hold_q + 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (latch) begin
      sub_a_d    = main_A;
      sub_dsn_d  = main_dsn;
      sub_rnw_d  = main_rnw;
      sub_dout_d = main_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      settle_q   <= '0;
      to_q       <= '0;
      sub_br_q   <= 1'b0;
      main_ok_q  <= 1'b0;
      main_din_q <= '0;
      tout_q     <= 1'b0;
      sub_a_q    <= '0;
      sub_dsn_q  <= 2'b11;
      sub_rnw_q  <= 1'b1;
      sub_dout_q <= '0;
`ifdef JTOUTRUN_SUBHOLD_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      to_q       <= to_d;
      sub_br_q   <= sub_br_d;
      main_ok_q  <= main_ok_d;
      main_din_q <= main_din_d;
      tout_q     <= tout_d;
      sub_a_q    <= sub_a_d;
      sub_dsn_q  <= sub_dsn_d;
      sub_rnw_q  <= sub_rnw_d;
      sub_dout_q <= sub_dout_d;
`ifdef JTOUTRUN_SUBHOLD_EN
      hold_q     <= hold_d;
`endif
    end
  end

  assign main_din = main_din_q;
  assign main_ok  = main_ok_q;
  assign sub_br   = sub_br_q;
  assign sub_A    = sub_a_q;
  assign sub_dsn  = sub_dsn_q;
  assign sub_rnw  = sub_rnw_q;
  assign sub_dout = sub_dout_q;
  assign tout     = tout_q;
endmodule

// File: tb/tb_jtoutrun_subbus.sv
// Directed bench for jtoutrun_subbus: read/write handshakes, settle window, timeout, abort, async reset.
module tb_jtoutrun_subbus;
  localparam int SETTLE = 2, TOW = 10, TIMEOUT = 1000, HOLD = 16;

  logic        clk = 1'b0, rst = 1'b1;
  logic        main_cs = 1'b0, main_rnw = 1'b1, sub_ok = 1'b0;
  logic [18:0] main_A = '0;
  logic [1:0]  main_dsn = 2'b11;
  logic [15:0] main_dout = '0, sub_din = '0;
  logic [15:0] main_din, sub_dout;
  logic        main_ok, sub_br, sub_rnw, tout;
  logic [18:0] sub_A;
  logic [1:0]  sub_dsn;

  int vecs = 0, errs = 0;

  jtoutrun_subbus #(.SETTLE(SETTLE), .TOW(TOW), .TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .main_cs(main_cs), .main_A(main_A), .main_dsn(main_dsn),
    .main_rnw(main_rnw), .main_dout(main_dout), .main_din(main_din), .main_ok(main_ok),
    .sub_br(sub_br), .sub_A(sub_A), .sub_dsn(sub_dsn), .sub_rnw(sub_rnw),
    .sub_dout(sub_dout), .sub_din(sub_din), .sub_ok(sub_ok), .tout(tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // one clock; outputs sampled and inputs driven 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // wait for main_ok, counting edges; bound keeps the bench from hanging
  task automatic wait_ok(input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!main_ok && n < bound);
  endtask

  // leave the bus idle long enough for any bus-keep window to lapse
  task automatic settle_idle();
`ifdef JTOUTRUN_SUBHOLD_EN
    repeat (HOLD + 2) step();
`else
    step();
`endif
  endtask

  // read with an immediate grant; main_ok due 3+SETTLE edges after main_cs is driven
  task automatic rd_imm(input string tag, input logic [18:0] a, input logic [15:0] d);
    int n;
    main_cs = 1'b1; main_A = a; main_rnw = 1'b1; main_dsn = 2'b00;
    sub_ok = 1'b1; sub_din = d;
    wait_ok(50, n);
    chk({tag, "_lat"}, n, 3 + SETTLE);
    chk({tag, "_din"}, main_din, d);
    main_cs = 1'b0; sub_ok = 1'b0;
    step();
    chk({tag, "_ok_off"}, main_ok, 0);
`ifdef JTOUTRUN_SUBHOLD_EN
    chk({tag, "_br_keep"}, sub_br, 1);
`else
    chk({tag, "_br_off"}, sub_br, 0);
`endif
  endtask

  initial begin
    int n;
    bit seen;
    // reset state
    repeat (2) step();
    chk("rst_br", sub_br, 0);
    chk("rst_ok", main_ok, 0);
    chk("rst_din", main_din, 0);
    chk("rst_tout", tout, 0);
    chk("rst_A", sub_A, 0);
    chk("rst_dsn", sub_dsn, 2'b11);
    chk("rst_rnw", sub_rnw, 1);
    chk("rst_dout", sub_dout, 0);
    rst = 1'b0;
    step();

    // read, grant arrives 4 cycles after sub_br
    main_cs = 1'b1; main_A = 19'h30000; main_rnw = 1'b1; main_dsn = 2'b00;
    step();
    chk("rd_br_on", sub_br, 1);
    chk("rd_A", sub_A, 19'h30000);
    repeat (4) step();
    chk("rd_wait_ok", main_ok, 0);
    sub_ok = 1'b1; sub_din = 16'h1234;
    wait_ok(50, n);
    chk("rd_lat", n, 2 + SETTLE);
    chk("rd_din", main_din, 16'h1234);
    step();
    chk("rd_ok_hold", main_ok, 1);
    chk("rd_br_hold", sub_br, 1);
    main_cs = 1'b0; sub_ok = 1'b0;
    step();
    chk("rd_ok_off", main_ok, 0);
`ifndef JTOUTRUN_SUBHOLD_EN
    chk("rd_br_off", sub_br, 0);
`endif
    settle_idle();

    // write; main_* wiggle after latching must not reach the sub bus
    main_cs = 1'b1; main_A = 19'h12345; main_rnw = 1'b0; main_dsn = 2'b10;
    main_dout = 16'hA55A; sub_ok = 1'b1; sub_din = 16'hBEEF;
    step();
    n = 0;
    do begin
      main_dout = ~main_dout; main_A = ~main_A; main_dsn = ~main_dsn;
      step();
      n++;
    end while (!main_ok && n < 50);
    chk("wr_lat", n, 2 + SETTLE);
    chk("wr_dsn", sub_dsn, 2'b10);
    chk("wr_rnw", sub_rnw, 0);
    chk("wr_dout", sub_dout, 16'hA55A);
    chk("wr_A", sub_A, 19'h12345);
    chk("wr_din_kept", main_din, 16'h1234);
    main_dout = 16'h0000;
    step();
    chk("wr_dout_done", sub_dout, 16'hA55A);
    main_cs = 1'b0; sub_ok = 1'b0;
    step();
    chk("wr_dout_idle", sub_dout, 16'hA55A);
    settle_idle();

    // grant pulses once inside the settle window, then drops for 10 cycles
    main_cs = 1'b1; main_A = 19'h00001; main_rnw = 1'b1; main_dsn = 2'b00;
    sub_din = 16'h5A5A;
    step();
    sub_ok = 1'b1;
    step();
    sub_ok = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      step();
      if (main_ok) seen = 1'b1;
    end
    chk("pulse_noack", seen, 0);
    sub_ok = 1'b1;
    step();
    chk("pulse_ack", main_ok, 1);
    chk("pulse_din", main_din, 16'h5A5A);
    main_cs = 1'b0; sub_ok = 1'b0;
    step();
    settle_idle();

    // aborted cycle: main_cs drops while still waiting for grant
    main_cs = 1'b1; main_A = 19'h00042;
    repeat (3) step();
    main_cs = 1'b0;
    step();
    chk("abort_br", sub_br, 0);
    step();
    chk("abort_ok", main_ok, 0);
    settle_idle();

    // no grant ever: forced completion after TIMEOUT cycles
    main_cs = 1'b1; main_A = 19'h00007; main_rnw = 1'b1;
    step();
    wait_ok(TIMEOUT + 100, n);
    chk("to_lat", n, TIMEOUT);
    chk("to_din", main_din, 16'hFFFF);
    chk("to_flag", tout, 1);
    main_cs = 1'b0;
    step();
    settle_idle();
    rd_imm("after_to", 19'h00100, 16'h0F0F);
    chk("to_sticky", tout, 1);
    settle_idle();

    // async reset mid-access
    main_cs = 1'b1; main_A = 19'h00200; main_rnw = 1'b1; sub_ok = 1'b1; sub_din = 16'h7777;
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_br", sub_br, 0);
    chk("arst_ok", main_ok, 0);
    chk("arst_tout", tout, 0);
    main_cs = 1'b0; sub_ok = 1'b0;
    #1 rst = 1'b0;
    step();
    rd_imm("after_rst", 19'h00300, 16'hC3C3);
    settle_idle();

`ifdef JTOUTRUN_SUBHOLD_EN
    // bus kept between two reads; second access skips the request phase
    rd_imm("keep1", 19'h00400, 16'h1111);
    seen = 1'b0;
    repeat (4) begin
      step();
      if (!sub_br) seen = 1'b1;
    end
    chk("keep_br_between", seen, 0);
    main_cs = 1'b1; main_A = 19'h00500; sub_ok = 1'b1; sub_din = 16'h2222;
    step();
    wait_ok(50, n);
    chk("keep_lat", n, SETTLE + 1);
    chk("keep_din", main_din, 16'h2222);
    main_cs = 1'b0; sub_ok = 1'b0;
    step();
    n = 0;
    do begin
      step();
      n++;
    end while (sub_br && n < 100);
    chk("keep_drop", n, HOLD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
